// File: rtl/freq_meter.sv
// Gated-window frequency meter.
// Counts rising edges of an asynchronous input over a window of exactly
// GATE_CYCLES reference clocks and reports the count, saturating at all-ones.
//
// Handshake: Start is a level sampled only while IDLE; it is not a valid/ready
// pair and is never queued. Valid is a one-cycle pulse, with no back-pressure,
// marking the cycle in which Freq_Out and Overflow take a new result. Both
// outputs hold that result until the next Valid.
module freq_meter #(
  parameter int CLK_Freq    = 50000000,
  parameter int GATE_CYCLES = CLK_Freq,
  parameter int CNT_W       = 27
) (
  input  logic             CLK_50M,
  input  logic             CR,
  input  logic             Sig_In,
  input  logic             Start,
  input  logic             Cont,
  output logic [CNT_W-1:0] Freq_Out,
  output logic             Valid,
  output logic             Overflow,
  output logic             Busy,
  output logic [1:0]       state_dbg
);

  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_next;
  logic               sync0, s1, s2, edge_r;
  logic [GATE_W-1:0]  gate_cnt;
  logic [CNT_W-1:0]   edge_cnt;
  logic               ovf;

  // Two-flop synchronizer, one history flop, then a registered rising-edge strobe
  always_ff @(posedge CLK_50M) begin
    if (CR) begin
      sync0  <= 1'b0;
      s1     <= 1'b0;
      s2     <= 1'b0;
      edge_r <= 1'b0;
    end else begin
      sync0  <= Sig_In;
      s1     <= sync0;
      s2     <= s1;
      edge_r <= s1 & ~s2;
    end
  end

  // State register
  always_ff @(posedge CLK_50M) begin
    if (CR) state <= IDLE;
    else    state <= state_next;
  end

  // Next-state logic: DONE always lasts one cycle, then re-arms or idles on Cont
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = GATE;
      GATE:    if (gate_cnt == GATE_LAST) state_next = DONE;
      DONE:    state_next = Cont ? GATE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Gate and edge counters; the last gate cycle's edge is still counted
  always_ff @(posedge CLK_50M) begin
    if (CR) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf      <= 1'b0;
          end
        end
        GATE: begin
          if (gate_cnt != GATE_LAST) gate_cnt <= gate_cnt + GATE_W'(1);
          if (edge_r) begin
            if (&edge_cnt) ovf <= 1'b1;
            else           edge_cnt <= edge_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          // Clear here so a continuous re-arm starts a fresh window without a dead cycle
          gate_cnt <= '0;
          edge_cnt <= '0;
          ovf      <= 1'b0;
        end
        default: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          ovf      <= 1'b0;
        end
      endcase
    end
  end

  // Result registers: publish the finished window as DONE ends
  always_ff @(posedge CLK_50M) begin
    if (CR) begin
      Freq_Out <= '0;
      Overflow <= 1'b0;
      Valid    <= 1'b0;
    end else begin
      Valid <= (state == DONE);
      if (state == DONE) begin
        Freq_Out <= edge_cnt;
        Overflow <= ovf;
      end
    end
  end

  assign Busy      = (state == GATE) || (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: 50-cycle gate, 6-bit and 3-bit counters.
module tb_freq_meter;

  localparam int GATE = 50;

  logic       clk = 1'b0;
  logic       cr;
  logic       sig_in;
  logic       start;
  logic       start_w3;
  logic       cont;
  logic [5:0] freq_out;
  logic       valid, overflow, busy;
  logic [1:0] state_dbg;
  logic [2:0] freq_w3;
  logic       valid_w3, overflow_w3, busy_w3;
  logic [1:0] state_w3;

  int sig_period = 0;
  bit sig_level  = 1'b0;
  int checks     = 0;
  int passed     = 0;

  freq_meter #(.CLK_Freq(50), .GATE_CYCLES(GATE), .CNT_W(6)) dut (
    .CLK_50M(clk), .CR(cr), .Sig_In(sig_in), .Start(start), .Cont(cont),
    .Freq_Out(freq_out), .Valid(valid), .Overflow(overflow), .Busy(busy),
    .state_dbg(state_dbg)
  );

  freq_meter #(.CLK_Freq(50), .GATE_CYCLES(GATE), .CNT_W(3)) dut_w3 (
    .CLK_50M(clk), .CR(cr), .Sig_In(sig_in), .Start(start_w3), .Cont(1'b0),
    .Freq_Out(freq_w3), .Valid(valid_w3), .Overflow(overflow_w3), .Busy(busy_w3),
    .state_dbg(state_w3)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Sig_In generator: periodic square wave, or a constant level when period is 0
  initial begin
    int ph;
    ph = 0;
    sig_in = 1'b0;
    forever begin
      @(negedge clk);
      if (sig_period != 0) begin
        ph = (ph + 1 >= sig_period) ? 0 : ph + 1;
        sig_in = (ph < sig_period / 2);
      end else begin
        sig_in = sig_level;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Pulse Start for one cycle; returns 1 time unit after the sampling edge
  task automatic pulse_start(input bit w3);
    @(negedge clk);
    if (w3) start_w3 = 1'b1;
    else    start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    start_w3 = 1'b0;
  endtask

  // Step cycles until Valid is seen (or max expires); n = cycles stepped
  task automatic wait_valid(input bit w3, input int max, output int n, output int busy_cnt);
    n = 0;
    busy_cnt = 0;
    forever begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      n++;
      if (w3 ? valid_w3 : valid) break;
      if (n >= max) break;
    end
  endtask

  task automatic count_valids(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (valid) cnt++;
    end
  endtask

  task automatic set_signal(input int period, input bit level);
    sig_period = period;
    sig_level  = level;
    repeat (8) @(posedge clk);
  endtask

  initial begin
    int n, bc, cnt;
    cr = 1'b1;
    start = 1'b0;
    start_w3 = 1'b0;
    cont = 1'b0;
    sig_period = 2;

    // 1. reset held with Sig_In toggling
    repeat (3) @(posedge clk);
    #1;
    check("rst_freq", freq_out, 0);
    check("rst_valid", valid, 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, 0);
    @(negedge clk);
    cr = 1'b0;

    // 2. period 10, single shot
    set_signal(10, 1'b0);
    pulse_start(1'b0);
    wait_valid(1'b0, 200, n, bc);
    check("t2_latency", n, 51);
    check("t2_freq", freq_out, 5);
    check("t2_ovf", overflow, 0);
    check("t2_busy_cycles", bc, 51);
    check("t2_busy_after", busy, 0);
    @(posedge clk);
    #1;
    check("t2_valid_pulse", valid, 0);
    check("t2_freq_hold", freq_out, 5);

    // 3. constant high input
    set_signal(0, 1'b1);
    pulse_start(1'b0);
    wait_valid(1'b0, 200, n, bc);
    check("t3_latency", n, 51);
    check("t3_freq", freq_out, 0);
    count_valids(60, cnt);
    check("t3_single_valid", cnt, 0);
    check("t3_state_idle", state_dbg, 0);

    // 4. continuous mode, period 5
    set_signal(5, 1'b0);
    cont = 1'b1;
    pulse_start(1'b0);
    wait_valid(1'b0, 200, n, bc);
    check("t4_first_latency", n, 51);
    check("t4_first_freq", freq_out, 10);
    for (int i = 0; i < 2; i++) begin
      wait_valid(1'b0, 200, n, bc);
      check("t4_period", n, 51);
      check("t4_freq", freq_out, 10);
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    cont = 1'b0;
    #1;
    wait_valid(1'b0, 200, n, bc);
    check("t4_last_latency", n, 41);
    check("t4_last_freq", freq_out, 10);
    check("t4_busy_low", busy, 0);
    count_valids(60, cnt);
    check("t4_no_more_valid", cnt, 0);

    // 5. 3-bit counter saturation, then recovery
    set_signal(4, 1'b0);
    pulse_start(1'b1);
    wait_valid(1'b1, 200, n, bc);
    check("t5_latency", n, 51);
    check("t5_sat_freq", freq_w3, 7);
    check("t5_sat_ovf", overflow_w3, 1);
    set_signal(10, 1'b0);
    pulse_start(1'b1);
    wait_valid(1'b1, 200, n, bc);
    check("t5_freq", freq_w3, 5);
    check("t5_ovf_clear", overflow_w3, 0);

    // 6. reset mid-gate aborts the run
    pulse_start(1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    cr = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_freq", freq_out, 0);
    check("t6_rst_state", state_dbg, 0);
    @(negedge clk);
    cr = 1'b0;
    count_valids(60, cnt);
    check("t6_no_aborted_valid", cnt, 0);
    pulse_start(1'b0);
    wait_valid(1'b0, 200, n, bc);
    check("t6_latency", n, 51);
    check("t6_freq", freq_out, 5);

    // Start during GATE is ignored
    pulse_start(1'b0);
    repeat (10) @(posedge clk);
    pulse_start(1'b0);
    wait_valid(1'b0, 200, n, bc);
    check("t6_ignored_start_latency", n, 40);
    check("t6_ignored_freq", freq_out, 5);
    count_valids(60, cnt);
    check("t6_no_extra_run", cnt, 0);
    check("t6_idle_busy", busy, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
